// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM access controller.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } mem_state_e;

  localparam int unsigned SRAM_DATA_W       = 16;
  localparam int unsigned DATA_BASE_DEFAULT = 1024;
  localparam int unsigned CNT_W             = 4;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// External asynchronous SRAM bus: the controller drives it, the SRAM answers on DQ_IN.
interface mem_stage_sram_ctrl_if
  import arm_mem_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 18
);

  logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
  logic [SRAM_DATA_W-1:0] SRAM_DQ_OUT;
  logic                   SRAM_DQ_OE;
  logic [SRAM_DATA_W-1:0] SRAM_DQ_IN;
  logic                   SRAM_WE_N;

  modport master (
    output SRAM_ADDR,
    output SRAM_DQ_OUT,
    output SRAM_DQ_OE,
    output SRAM_WE_N,
    input  SRAM_DQ_IN
  );

  modport slave (
    input  SRAM_ADDR,
    input  SRAM_DQ_OUT,
    input  SRAM_DQ_OE,
    input  SRAM_WE_N,
    output SRAM_DQ_IN
  );

endinterface

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Per-half-access wait counter; tc flags the last of WAIT_CYCLES held cycles.
module mem_wait_counter
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: each 32-bit load/store becomes two 16-bit SRAM
// half-accesses (low half first), stalling the pipeline via ready until DONE.
module mem_stage_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         MEM_R_EN,
  input  logic                         MEM_W_EN,
  input  logic [31:0]                  ALU_result,
  input  logic [31:0]                  ST_val,
  output logic                         ready,
  output logic [31:0]                  MEM_result,
  mem_stage_sram_ctrl_if.master        sram
);

  mem_state_e  state, state_nxt;
  logic        req;
  logic        is_load;
  logic        active;
  logic        tc;
  logic        half;
  logic [31:0] offset;
  logic        offset_unused;

  assign req     = MEM_R_EN | MEM_W_EN;
  assign is_load = MEM_R_EN & ~MEM_W_EN;
  assign active  = (state == LOW) || (state == HIGH);
  assign offset  = ALU_result - DATA_BASE;
  // Byte offset bits and bits beyond the SRAM word range play no part in the address.
  assign offset_unused = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  mem_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (~active | tc),
    .en  (active),
    .tc  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = LOW;
      LOW:     if (tc)  state_nxt = HIGH;
      HIGH:    if (tc)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = ~req | (state == DONE);

  // WE_N is released on the final count so its rising edge sees stable address/data.
  always_comb begin
    half             = (state == HIGH);
    sram.SRAM_ADDR   = '0;
    sram.SRAM_DQ_OUT = '0;
    sram.SRAM_DQ_OE  = 1'b0;
    sram.SRAM_WE_N   = 1'b1;
    if (active) begin
      sram.SRAM_ADDR = {offset[SRAM_ADDR_W:2], half};
      if (MEM_W_EN) begin
        sram.SRAM_DQ_OE  = 1'b1;
        sram.SRAM_WE_N   = tc;
        sram.SRAM_DQ_OUT = half ? ST_val[31:16] : ST_val[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_result <= '0;
    end else if (is_load && tc) begin
      if (state == LOW) begin
        MEM_result[15:0] <= sram.SRAM_DQ_IN;
      end else if (state == HIGH) begin
        MEM_result[31:16] <= sram.SRAM_DQ_IN;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small behavioural async SRAM.
module tb_mem_stage_sram_ctrl;

  localparam int unsigned W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en;
  logic        w_en;
  logic [31:0] alu;
  logic [31:0] st;
  logic        ready;
  logic [31:0] mem_result;
  logic [15:0] mem [0:63];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl_if #(.SRAM_ADDR_W(18)) sram_if ();

  mem_stage_sram_ctrl #(
    .WAIT_CYCLES (W),
    .SRAM_ADDR_W (18),
    .DATA_BASE   (32'd1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (r_en),
    .MEM_W_EN   (w_en),
    .ALU_result (alu),
    .ST_val     (st),
    .ready      (ready),
    .MEM_result (mem_result),
    .sram       (sram_if.master)
  );

  assign sram_if.SRAM_DQ_IN = mem[sram_if.SRAM_ADDR[5:0]];

  always @(posedge sram_if.SRAM_WE_N) begin
    if (sram_if.SRAM_DQ_OE === 1'b1) mem[sram_if.SRAM_ADDR[5:0]] <= sram_if.SRAM_DQ_OUT;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: that cycle is cycle 0 of the access; returns at the DONE negedge.
  task automatic access(input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] a0);
    int unsigned we_low;
    logic        hi;
    logic [31:0] we_exp;
    we_low = 0;
    r_en = r; w_en = w; alu = addr; st = data;
    #1;
    check("start_ready", {31'd0, ready}, 32'd0);
    for (int unsigned c = 1; c <= 2 * W + 1; c++) begin
      @(negedge clk);
      if (c <= 2 * W) begin
        hi     = (c > W);
        we_exp = (w && !(c == W || c == 2 * W)) ? 32'd0 : 32'd1;
        check("busy_ready", {31'd0, ready}, 32'd0);
        check("addr", {14'd0, sram_if.SRAM_ADDR}, a0 + {31'd0, hi});
        check("dq_oe", {31'd0, sram_if.SRAM_DQ_OE}, {31'd0, w});
        check("we_n", {31'd0, sram_if.SRAM_WE_N}, we_exp);
        if (w) check("dq_out", {16'd0, sram_if.SRAM_DQ_OUT}, hi ? {16'd0, data[31:16]} : {16'd0, data[15:0]});
        if (sram_if.SRAM_WE_N === 1'b0) we_low++;
      end else begin
        check("done_ready", {31'd0, ready}, 32'd1);
        check("done_addr", {14'd0, sram_if.SRAM_ADDR}, 32'd0);
        check("done_we_n", {31'd0, sram_if.SRAM_WE_N}, 32'd1);
      end
    end
    check("we_low_cycles", we_low, w ? 32'd6 : 32'd0);
  endtask

  initial begin
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0; alu = '0; st = '0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[2] = 16'h5678;
    mem[3] = 16'h1234;
    #1 rst = 1'b0;
    #11;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_result", mem_result, 32'd0);
    check("rst_addr", {14'd0, sram_if.SRAM_ADDR}, 32'd0);
    check("rst_dq_out", {16'd0, sram_if.SRAM_DQ_OUT}, 32'd0);
    check("rst_dq_oe", {31'd0, sram_if.SRAM_DQ_OE}, 32'd0);
    check("rst_we_n", {31'd0, sram_if.SRAM_WE_N}, 32'd1);
    @(negedge clk) rst = 1'b1;

    // Store 0xDEADBEEF to 1024 -> halves 0,1
    @(negedge clk);
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0);
    w_en = 1'b0;
    check("st_mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    check("st_mem1", {16'd0, mem[1]}, 32'h0000DEAD);
    check("st_result", mem_result, 32'd0);

    // Load from 1028 -> halves 2,3
    @(negedge clk);
    access(1'b1, 1'b0, 32'd1028, 32'd0, 32'd2);
    check("ld_result", mem_result, 32'h12345678);
    r_en = 1'b0;

    // Both enables: store wins, load result untouched
    @(negedge clk);
    access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 32'd4);
    check("both_result", mem_result, 32'h12345678);
    check("both_mem4", {16'd0, mem[4]}, 32'h0000F00D);
    check("both_mem5", {16'd0, mem[5]}, 32'h0000CAFE);
    r_en = 1'b0; w_en = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, sram_if.SRAM_WE_N}, 32'd1);
      check("idle_dq_oe", {31'd0, sram_if.SRAM_DQ_OE}, 32'd0);
      check("idle_addr", {14'd0, sram_if.SRAM_ADDR}, 32'd0);
    end

    // Reset asserted in HIGH of a load
    @(negedge clk);
    r_en = 1'b1; alu = 32'd1028;
    for (int i = 0; i < int'(W) + 2; i++) @(negedge clk);
    check("pre_rst_addr", {14'd0, sram_if.SRAM_ADDR}, 32'd3);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_result", mem_result, 32'd0);
    check("mid_rst_we_n", {31'd0, sram_if.SRAM_WE_N}, 32'd1);
    check("mid_rst_dq_oe", {31'd0, sram_if.SRAM_DQ_OE}, 32'd0);
    check("mid_rst_addr", {14'd0, sram_if.SRAM_ADDR}, 32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk) rst = 1'b1;
    access(1'b1, 1'b0, 32'd1028, 32'd0, 32'd2);
    check("restart_result", mem_result, 32'h12345678);
    r_en = 1'b0;

    // Back-to-back stores with one IDLE cycle between
    @(negedge clk);
    access(1'b0, 1'b1, 32'd1024, 32'h11112222, 32'd0);
    alu = 32'd1032; st = 32'h33334444;
    @(negedge clk);
    check("gap_ready", {31'd0, ready}, 32'd0);
    check("gap_addr", {14'd0, sram_if.SRAM_ADDR}, 32'd0);
    check("gap_we_n", {31'd0, sram_if.SRAM_WE_N}, 32'd1);
    access(1'b0, 1'b1, 32'd1032, 32'h33334444, 32'd4);
    w_en = 1'b0;
    check("b2b_mem0", {16'd0, mem[0]}, 32'h00002222);
    check("b2b_mem1", {16'd0, mem[1]}, 32'h00001111);
    check("b2b_mem4", {16'd0, mem[4]}, 32'h00004444);
    check("b2b_mem5", {16'd0, mem[5]}, 32'h00003333);
    check("b2b_result", mem_result, 32'h12345678);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
